// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle for the multiply/divide unit.
//   start, op[1:0], A[31:0], B[31:0]         : request (master -> slave)
//   busy, done, HiEnable, LoEnable, dz        : status/strobes (slave -> master)
//   HiOut[31:0], LoOut[31:0]                  : result (slave -> master)
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        HiEnable;
    logic        LoEnable;
    logic        dz;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    modport master (
        output start, op, A, B,
        input  busy, done, HiEnable, LoEnable, dz, HiOut, LoOut
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, HiEnable, LoEnable, dz, HiOut, LoOut
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU).
//   clk_i : clock, all state changes on the rising edge
//   clr_i : synchronous active-low reset
//   bus   : mult_div_unit_if.slave
//           op 00=MULT 01=MULTU 10=DIV 11=DIVU; A = rs/dividend, B = rt/divisor
//           MULT*: Hi/Lo = product[63:32]/[31:0]; DIV*: Hi = remainder, Lo = quotient
//           done/HiEnable/LoEnable pulse for one cycle with the result; dz flags B=0 on DIV*.
// Sequence: IDLE -> PREP -> ITER (32 cycles) -> FIX -> DONE -> IDLE.
// Divide by zero short-cuts PREP -> DONE.
module mult_div_unit (
    input  logic              clk_i,
    input  logic              clr_i,
    mult_div_unit_if.slave    bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state_q,   state_d;
    logic [1:0]  op_q,      op_d;
    logic [31:0] a_q,       a_d;
    logic [31:0] b_q,       b_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [63:0] acc_q,     acc_d;
    logic [31:0] dvs_q,     dvs_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dzf_q,     dzf_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;

    logic        is_signed;
    logic        is_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [31:0] fix_q;
    logic [31:0] fix_r;
    logic [63:0] fix_p;

    always_comb begin
        is_signed = ~op_q[0];
        is_div    = op_q[1];
        mag_a     = (is_signed && a_q[31]) ? -a_q : a_q;
        mag_b     = (is_signed && b_q[31]) ? -b_q : b_q;

        // Multiply: acc holds {partial product high, remaining multiplier bits};
        // add the multiplicand on the current LSB and shift the 33-bit sum back in.
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);

        // Divide: acc holds {remainder, dividend/quotient}; the shifted remainder
        // needs 33 bits since it may exceed 32 bits before the subtraction.
        div_diff  = acc_q[63:31] - {1'b0, dvs_q};

        fix_p     = neg_res_q ? -acc_q : acc_q;
        fix_q     = neg_res_q ? -acc_q[31:0]  : acc_q[31:0];
        fix_r     = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dzf_d     = dzf_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    dzf_d   = 1'b0;
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_res_d = is_signed & (a_q[31] ^ b_q[31]);
                neg_rem_d = is_signed & a_q[31];
                cnt_d     = '0;
                if (is_div && (b_q == '0)) begin
                    hi_d    = a_q;
                    lo_d    = '1;
                    dzf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    dvs_d   = is_div ? mag_b : mag_a;
                    acc_d   = {32'd0, (is_div ? mag_a : mag_b)};
                    state_d = ITER;
                end
            end
            ITER: begin
                if (is_div) begin
                    if (!div_diff[32]) begin
                        acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[62:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div) begin
                    hi_d = fix_r;
                    lo_d = fix_q;
                end else begin
                    hi_d = fix_p[63:32];
                    lo_d = fix_p[31:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dzf_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dzf_q     <= dzf_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.HiEnable = (state_q == DONE);
    assign bus.LoEnable = (state_q == DONE);
    assign bus.dz       = (state_q == DONE) & dzf_q;
    assign bus.HiOut    = hi_q;
    assign bus.LoOut    = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits.
REQ-002 Clk  in  1  single clock; all state changes on the rising edge.
REQ-003 clr  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
REQ-006 A  in  32  rs operand (register-file port PA); dividend for DIV/DIVU.
REQ-007 B  in  32  rt operand (register-file port PB); divisor for DIV/DIVU.
REQ-008 busy  out  1  high while an operation is in progress (PREP, ITER, FIX, DONE).
REQ-009 done  out  1  one-cycle pulse; result valid on HiOut/LoOut.
REQ-010 HiEnable, LoEnable  out  1 each  write strobes to the Hi/Lo registers; each is identical to done.
REQ-011 HiOut, LoOut  out  32 each  result; MULT*: Hi=product[63:32], Lo=product[31:0]; DIV*: Hi=remainder, Lo=quotient.
REQ-012 dz  out  1  one-cycle pulse coincident with done when DIV/DIVU has B=0.

Function
REQ-013 The FSM shall have states IDLE, PREP, ITER, FIX and DONE.
REQ-014 In IDLE with start=1, the block shall latch A, B and op, and the next state shall be PREP; with start=0 it shall stay in IDLE.
REQ-015 The block shall ignore start in every state except IDLE: no queuing, and the latched operands are unaffected.
REQ-016 PREP (1 cycle), signed ops: take operand magnitudes (two's-complement negate when negative) and record the result signs; unsigned ops: pass operands unchanged.
REQ-017 PREP with DIV/DIVU and B=0: the next state shall be DONE with Hi=A (original), Lo=32'hFFFFFFFF and dz=1, skipping ITER and FIX.
REQ-018 ITER shall last exactly 32 cycles, counted by a 5-bit counter from 0 to 31; ITER exits to FIX after count 31.
REQ-019 Multiply in ITER: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
REQ-020 Divide in ITER: restoring division; per cycle, shift the remainder:quotient left, subtract the divisor, and keep the result if it is non-negative (33-bit compare).
REQ-021 FIX (1 cycle), MULT: negate the 64-bit product iff the operand signs differ.
REQ-022 FIX (1 cycle), DIV: negate the quotient iff the operand signs differ; the remainder shall take the sign of the dividend.
REQ-023 DIV 32'h80000000 / 32'hFFFFFFFF shall wrap to Lo=32'h80000000, Hi=0, with no flag.
REQ-024 DONE (1 cycle): done=HiEnable=LoEnable=1 and HiOut/LoOut driven with the result; the next state shall be IDLE.
REQ-025 Latency: with start sampled at edge k, done shall be high in the cycle following edge k+34 (PREP 1, ITER 32, FIX 1, DONE 1); for divide-by-zero, done shall be high in the cycle following edge k+1.
REQ-026 HiOut/LoOut shall hold the last result until the next DONE; busy shall fall on the edge leaving DONE.
REQ-027 A start asserted in the DONE cycle shall be ignored; back-to-back operations shall be accepted no earlier than the first IDLE cycle.
REQ-028 dz shall be 0 for all MULT/MULTU operations and for DIV/DIVU with B≠0.

Reset
REQ-029 clr=0 at a rising edge shall force IDLE and clear busy, done, HiEnable, LoEnable and dz to 0, HiOut/LoOut to 32'h0, and the counter and accumulators to 0.
REQ-030 Reset asserted mid-operation shall abort the operation: no done or enable pulse shall follow, and operand latches shall be discarded.
REQ-031 Reset shall take priority over start in the same cycle.

Verification
REQ-032 MULT A=32'hFFFFFFFD (-3), B=7 -> done 35 cycles after start, Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB, HiEnable=LoEnable=1 for one cycle.
REQ-033 MULTU A=B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001.
REQ-034 DIV A=-7, B=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; DIVU A=7, B=2 -> Lo=3, Hi=1.
REQ-035 DIV A=32'h80000000, B=32'hFFFFFFFF -> Lo=32'h80000000, Hi=0, dz=0.
REQ-036 DIVU A=32'h1234, B=0 -> done and dz high 2 cycles after start, Hi=32'h1234, Lo=32'hFFFFFFFF.
REQ-037 Reset and start-while-busy: start MULT, pulse start again at ITER count 5 (must be ignored), assert clr=0 at count 10 -> busy=0 next cycle, no done ever follows, HiOut=LoOut=0; a new start then completes normally.
